// File: rtl/uart_pkg.sv
// Shared types and constants for the parameterised UART transceiver:
// FSM state enums, parity mode encodings and rx_err bit positions.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PAR,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PAR,
        RX_STOP
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int ERR_PARITY  = 0;
    localparam int ERR_FRAME   = 1;
    localparam int ERR_OVERRUN = 2;

    // Words narrower than 9 bits are zero-extended, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [8:0] word, input int mode);
        return (^word) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO. A push into a full FIFO is dropped
// and flagged as overrun unless a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop_req,
    output logic [DATA_W-1:0]             head,
    output logic                          valid,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overrun
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              full;
    logic              pop;
    logic              push_ok;

    // Handshake: head is valid whenever valid is high; a pop happens on any
    // clock edge where valid && pop_req, and pop_req is ignored while empty.
    assign valid   = (count != '0);
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign pop     = valid && pop_req;
    assign push_ok = push && (!full || pop);
    assign overrun = push && full && !pop;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // At full with a simultaneous pop, the write lands on the slot being read out.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_xcvr_param.sv
// Parameterised UART transmitter/receiver with a receive FIFO and sticky
// error flags; both FSM states are exported for observation.
module uart_xcvr_param
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 347,
    parameter int DATA_W     = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        tx_start,
    input  logic [DATA_W-1:0]           tx_data,
    output logic                        tx_busy,
    output logic                        tx_finish,
    output logic                        ser_tx,
    input  logic                        ser_rx,
    output logic [DATA_W-1:0]           rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(FIFO_DEPTH):0] rx_count,
    output logic                        rx_finish,
    output logic [2:0]                  rx_err,
    input  logic                        err_clr,
    output tx_state_t                   tx_state,
    output rx_state_t                   rx_state
);

    localparam int CW = $clog2(STOP_BITS * CLK_DIV + 1);

    tx_state_t         tx_next;
    logic [CW-1:0]     tx_cnt, tx_cnt_d;
    logic [3:0]        tx_idx, tx_idx_d;
    logic [DATA_W-1:0] tx_sh, tx_sh_d;
    logic              tx_par, tx_par_d, ser_tx_d;
    logic              tx_bit_end, tx_stop_end;

    assign tx_bit_end  = (tx_cnt == CW'(CLK_DIV - 1));
    assign tx_stop_end = (tx_cnt == CW'(STOP_BITS * CLK_DIV - 1));
    assign tx_busy     = (tx_state != TX_IDLE);

    always_comb begin
        tx_next   = tx_state;
        tx_cnt_d  = tx_cnt + 1'b1;
        tx_idx_d  = tx_idx;
        tx_sh_d   = tx_sh;
        tx_par_d  = tx_par;
        tx_finish = 1'b0;
        ser_tx_d  = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (tx_start) begin
                    tx_next  = TX_START;
                    tx_sh_d  = tx_data;
                    tx_par_d = parity_bit(9'(tx_data), PARITY);
                end
            end
            TX_START: if (tx_bit_end) begin
                tx_next  = TX_DATA;
                tx_cnt_d = '0;
                tx_idx_d = '0;
            end
            TX_DATA: if (tx_bit_end) begin
                tx_cnt_d = '0;
                tx_sh_d  = tx_sh >> 1;
                tx_idx_d = tx_idx + 1'b1;
                if (tx_idx == 4'(DATA_W - 1)) begin
                    if (PARITY == PAR_NONE) tx_next = TX_STOP;
                    else                    tx_next = TX_PAR;
                end
            end
            TX_PAR: if (tx_bit_end) begin
                tx_next  = TX_STOP;
                tx_cnt_d = '0;
            end
            TX_STOP: if (tx_stop_end) begin
                // A start request on the last stop cycle chains the next frame with no gap.
                tx_finish = 1'b1;
                tx_cnt_d  = '0;
                tx_next   = TX_IDLE;
                if (tx_start) begin
                    tx_next  = TX_START;
                    tx_sh_d  = tx_data;
                    tx_par_d = parity_bit(9'(tx_data), PARITY);
                end
            end
            default: tx_next = TX_IDLE;
        endcase
        case (tx_next)
            TX_START: ser_tx_d = 1'b0;
            TX_DATA:  ser_tx_d = tx_sh_d[0];
            TX_PAR:   ser_tx_d = tx_par_d;
            default:  ser_tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            ser_tx   <= 1'b1;
        end else begin
            tx_state <= tx_next;
            tx_cnt   <= tx_cnt_d;
            tx_idx   <= tx_idx_d;
            tx_sh    <= tx_sh_d;
            tx_par   <= tx_par_d;
            ser_tx   <= ser_tx_d;
        end
    end

    logic [1:0]        rx_sync;
    logic              rx_prev, rx_s;
    rx_state_t         rx_next;
    logic [CW-1:0]     rx_cnt, rx_cnt_d;
    logic [3:0]        rx_idx, rx_idx_d;
    logic [DATA_W-1:0] rx_sh, rx_sh_d;
    logic              rx_par, rx_par_d;
    logic              rx_bit_end, rx_half;
    logic              frame_err, par_err, overrun;
    logic [2:0]        err_set;

    assign rx_s       = rx_sync[1];
    assign rx_bit_end = (rx_cnt == CW'(CLK_DIV - 1));
    assign rx_half    = (rx_cnt == CW'(CLK_DIV / 2 - 1));

    always_comb begin
        rx_next   = rx_state;
        rx_cnt_d  = rx_cnt + 1'b1;
        rx_idx_d  = rx_idx;
        rx_sh_d   = rx_sh;
        rx_par_d  = rx_par;
        rx_finish = 1'b0;
        frame_err = 1'b0;
        par_err   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev && !rx_s) rx_next = RX_START;
            end
            RX_START: if (rx_half) begin
                rx_cnt_d = '0;
                rx_idx_d = '0;
                if (rx_s) rx_next = RX_IDLE;
                else      rx_next = RX_DATA;
            end
            RX_DATA: if (rx_bit_end) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_s, rx_sh[DATA_W-1:1]};
                rx_idx_d = rx_idx + 1'b1;
                if (rx_idx == 4'(DATA_W - 1)) begin
                    if (PARITY == PAR_NONE) rx_next = RX_STOP;
                    else                    rx_next = RX_PAR;
                end
            end
            RX_PAR: if (rx_bit_end) begin
                rx_cnt_d = '0;
                rx_par_d = rx_s;
                rx_next  = RX_STOP;
            end
            RX_STOP: if (rx_bit_end) begin
                // Only the first stop bit is sampled; later stop bits act as idle line.
                rx_finish = 1'b1;
                frame_err = !rx_s;
                par_err   = (PARITY != PAR_NONE) && (rx_par != parity_bit(9'(rx_sh), PARITY));
                rx_next   = RX_IDLE;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_sh    <= '0;
            rx_par   <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], ser_rx};
            rx_prev  <= rx_s;
            rx_state <= rx_next;
            rx_cnt   <= rx_cnt_d;
            rx_idx   <= rx_idx_d;
            rx_sh    <= rx_sh_d;
            rx_par   <= rx_par_d;
        end
    end

    uart_rx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .push      (rx_finish),
        .push_data (rx_sh),
        .pop_req   (rx_ready),
        .head      (rx_data),
        .valid     (rx_valid),
        .count     (rx_count),
        .overrun   (overrun)
    );

    always_comb begin
        err_set              = '0;
        err_set[ERR_PARITY]  = par_err;
        err_set[ERR_FRAME]   = frame_err;
        err_set[ERR_OVERRUN] = overrun;
    end

    // A clear and a new error in the same cycle leave the new error set.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)     rx_err <= '0;
        else if (err_clr) rx_err <= err_set;
        else              rx_err <= rx_err | err_set;
    end

endmodule

// File: tb/tb_uart_xcvr_param.sv
// Directed-plus-random bench for uart_xcvr_param: an 8N1 depth-4 instance and
// an even-parity two-stop-bit instance, checked against a frame-level model.
module tb_uart_xcvr_param;
    import uart_pkg::*;

    localparam int CD    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CNTW  = $clog2(DEPTH) + 1;

    // clock / reset and shared stimulus
    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          tx_start = 1'b0;
    logic [DW-1:0] tx_data  = '0;
    logic          rx_ready = 1'b0;
    logic          err_clr  = 1'b0;
    logic          loop     = 1'b0;
    logic          rx_drive = 1'b1;

    always #5 clk = ~clk;

    // instance A: 8N1
    logic            tx_busy_a, tx_finish_a, ser_tx_a, ser_rx_a, rx_valid_a, rx_finish_a;
    logic [DW-1:0]   rx_data_a;
    logic [CNTW-1:0] rx_count_a;
    logic [2:0]      rx_err_a;
    tx_state_t       tx_st_a;
    rx_state_t       rx_st_a;
    // instance P: 8E2
    logic            tx_busy_p, tx_finish_p, ser_tx_p, ser_rx_p, rx_valid_p, rx_finish_p;
    logic [DW-1:0]   rx_data_p;
    logic [CNTW-1:0] rx_count_p;
    logic [2:0]      rx_err_p;
    tx_state_t       tx_st_p;
    rx_state_t       rx_st_p;

    assign ser_rx_a = loop ? ser_tx_a : rx_drive;
    assign ser_rx_p = loop ? ser_tx_p : rx_drive;

    uart_xcvr_param #(.CLK_DIV(CD), .DATA_W(DW), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy_a), .tx_finish(tx_finish_a), .ser_tx(ser_tx_a), .ser_rx(ser_rx_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready), .rx_count(rx_count_a),
        .rx_finish(rx_finish_a), .rx_err(rx_err_a), .err_clr(err_clr),
        .tx_state(tx_st_a), .rx_state(rx_st_a)
    );

    uart_xcvr_param #(.CLK_DIV(CD), .DATA_W(DW), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_p (
        .wb_clk_i(clk), .wb_rst_i(rst), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy_p), .tx_finish(tx_finish_p), .ser_tx(ser_tx_p), .ser_rx(ser_rx_p),
        .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ready(rx_ready), .rx_count(rx_count_p),
        .rx_finish(rx_finish_p), .rx_err(rx_err_p), .err_clr(err_clr),
        .tx_state(tx_st_p), .rx_state(rx_st_p)
    );

    // pulse monitors, sampled on the falling edge
    int rxf_a = 0;
    int txf_a = 0;
    always @(negedge clk) begin
        if (rx_finish_a) rxf_a++;
        if (tx_finish_a) txf_a++;
    end

    // scoreboard
    logic [DW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference model: a frame is start(0), data LSB first, optional parity, stop ones
    function automatic int frame_len(input int par_mode, input int stops);
        return 1 + DW + ((par_mode != PAR_NONE) ? 1 : 0) + stops;
    endfunction

    function automatic logic [15:0] frame_bits(input logic [DW-1:0] d, input int par_mode);
        logic [15:0] v;
        int ones;
        v = '1;
        v[0] = 1'b0;
        ones = $countones(d);
        for (int i = 0; i < DW; i++) v[1+i] = d[i];
        if (par_mode == PAR_EVEN) v[1+DW] = (ones % 2 == 1);
        if (par_mode == PAR_ODD)  v[1+DW] = (ones % 2 == 0);
        return v;
    endfunction

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tx_frame_check(input string pfx, input bit sel, input logic [DW-1:0] d);
        int len, bad, fin_n, fin_at, pm;
        logic [15:0] fb;
        logic obs_par;
        pm = sel ? PAR_EVEN : PAR_NONE;
        len = frame_len(pm, sel ? 2 : 1);
        fb = frame_bits(d, pm);
        bad = 0; fin_n = 0; fin_at = 0; obs_par = 1'bx;
        tx_data = d;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        check({pfx, "_busy_rise"}, sel ? tx_busy_p : tx_busy_a, 1);
        for (int c = 1; c <= len * CD; c++) begin
            if ((sel ? ser_tx_p : ser_tx_a) !== fb[(c-1)/CD]) bad++;
            if (sel ? tx_finish_p : tx_finish_a) begin
                fin_n++;
                fin_at = c;
            end
            if (c == (1 + DW) * CD + CD / 2) obs_par = ser_tx_p;
            tick(1);
        end
        check({pfx, "_wave_bad_cycles"}, bad, 0);
        check({pfx, "_finish_count"}, fin_n, 1);
        check({pfx, "_finish_cycle"}, fin_at, len * CD);
        check({pfx, "_busy_fall"}, sel ? tx_busy_p : tx_busy_a, 0);
        if (sel) check({pfx, "_parity_bit"}, obs_par, fb[1+DW]);
    endtask

    task automatic rx_frame(input logic [DW-1:0] d, input bit with_par, input logic pbit,
                            input logic stop, input int nstop);
        rx_drive = 1'b0;
        tick(CD);
        for (int i = 0; i < DW; i++) begin
            rx_drive = d[i];
            tick(CD);
        end
        if (with_par) begin
            rx_drive = pbit;
            tick(CD);
        end
        for (int s = 0; s < nstop; s++) begin
            rx_drive = (s == 0) ? stop : 1'b1;
            tick(CD);
        end
        rx_drive = 1'b1;
        tick(CD);
    endtask

    task automatic pop_check(input string tag);
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        check({tag, "_valid"}, rx_valid_a, 1);
        check({tag, "_data"}, rx_data_a, e);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, t0, i;
        logic [DW-1:0] w;
        logic [15:0] fb;

        // reset state
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_ser_tx", ser_tx_a, 1);
        check("rst_tx_busy", tx_busy_a, 0);
        check("rst_tx_finish", tx_finish_a, 0);
        check("rst_rx_finish", rx_finish_a, 0);
        check("rst_rx_valid", rx_valid_a, 0);
        check("rst_rx_count", rx_count_a, 0);
        check("rst_rx_err", rx_err_a, 0);
        check("rst_tx_state", tx_st_a, TX_IDLE);
        check("rst_rx_state", rx_st_a, RX_IDLE);
        check("rst_p_ser_tx", ser_tx_p, 1);

        // 8N1 waveform of 15
        tx_frame_check("tx15", 1'b0, 8'd15);

        // loopback with tx_start held: 61 then 79 back to back
        loop = 1'b1;
        tick(2);
        f0 = rxf_a;
        tx_data = 8'd61;
        tx_start = 1'b1;
        tick(1);
        tx_data = 8'd79;
        for (i = 0; i < 200 && !tx_finish_a; i++) tick(1);
        check("b2b_first_finish", tx_finish_a, 1);
        tick(1);
        tx_start = 1'b0;
        check("b2b_no_gap_busy", tx_busy_a, 1);
        check("b2b_no_gap_start", ser_tx_a, 0);
        exp_q.push_back(8'd61);
        exp_q.push_back(8'd79);
        for (i = 0; i < 200 && tx_busy_a; i++) tick(1);
        check("b2b_tx_done", tx_busy_a, 0);
        tick(CD);
        check("lb_rx_finish_pulses", rxf_a - f0, 2);
        check("lb_rx_count", rx_count_a, 2);
        check("lb_rx_err", rx_err_a, 0);
        pop_check("lb_pop0");
        pop_check("lb_pop1");

        // random loopback words
        for (int k = 0; k < 3; k++) begin
            w = DW'($urandom_range(0, 255));
            tx_frame_check("lb_rand", 1'b0, w);
            exp_q.push_back(w);
        end
        check("rand_rx_count", rx_count_a, 3);
        for (int k = 0; k < 3; k++) pop_check("rand_pop");
        check("rand_rx_err", rx_err_a, 0);

        // overrun: five frames into a depth-4 FIFO
        for (int k = 0; k < 5; k++) begin
            w = DW'($urandom_range(0, 255));
            tx_frame_check("ovr_tx", 1'b0, w);
            if (k < 4) exp_q.push_back(w);
        end
        check("ovr_rx_count", rx_count_a, 4);
        check("ovr_rx_err", rx_err_a, 3'b100);
        // push and pop in the same cycle while full
        w = DW'($urandom_range(0, 255));
        tx_data = w;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        for (i = 0; i < 200 && !rx_finish_a; i++) tick(1);
        check("full_pushpop_seen", rx_finish_a, 1);
        pop_check("full_pushpop_head");
        exp_q.push_back(w);
        check("full_pushpop_count", rx_count_a, 4);
        for (i = 0; i < 200 && tx_busy_a; i++) tick(1);
        for (int k = 0; k < 4; k++) pop_check("ovr_drain");
        check("ovr_drained_count", rx_count_a, 0);
        check("ovr_drained_valid", rx_valid_a, 0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("ovr_err_clr", rx_err_a, 0);

        // false start: 3-cycle glitch
        loop = 1'b0;
        tick(CD);
        f0 = rxf_a;
        rx_drive = 1'b0;
        tick(3);
        rx_drive = 1'b1;
        tick(3 * CD);
        check("glitch_no_finish", rxf_a - f0, 0);
        check("glitch_rx_idle", rx_st_a, RX_IDLE);
        check("glitch_rx_count", rx_count_a, 0);

        // stop bit forced low, then a good driven frame
        w = DW'($urandom_range(0, 255));
        f0 = rxf_a;
        rx_frame(w, 1'b0, 1'b0, 1'b0, 1);
        exp_q.push_back(w);
        check("ferr_finish", rxf_a - f0, 1);
        check("ferr_rx_err", rx_err_a, 3'b010);
        check("ferr_rx_count", rx_count_a, 1);
        pop_check("ferr_pop");
        w = DW'($urandom_range(0, 255));
        rx_frame(w, 1'b0, 1'b0, 1'b1, 1);
        exp_q.push_back(w);
        check("good_after_ferr_err", rx_err_a, 3'b010);
        pop_check("good_after_ferr_pop");
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("ferr_err_clr", rx_err_a, 0);

        // reset in the middle of data bit 3
        w = DW'($urandom_range(0, 255));
        fb = frame_bits(w, PAR_NONE);
        tx_data = w;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        tick(35);
        check("midrst_bit3", ser_tx_a, fb[4]);
        t0 = txf_a;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_ser_tx", ser_tx_a, 1);
        check("midrst_busy", tx_busy_a, 0);
        check("midrst_tx_state", tx_st_a, TX_IDLE);
        tick(100);
        check("midrst_no_finish", txf_a - t0, 0);
        tx_frame_check("after_rst", 1'b0, DW'($urandom_range(0, 255)));

        // even parity, two stop bits
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        loop = 1'b1;
        tick(2);
        tx_frame_check("p41", 1'b1, 8'd41);
        check("p41_rx_count", rx_count_p, 1);
        check("p41_rx_data", rx_data_p, 8'd41);
        check("p41_rx_err", rx_err_p, 0);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        w = DW'($urandom_range(0, 255));
        tx_frame_check("p_rand", 1'b1, w);
        check("p_rand_rx_data", rx_data_p, w);
        check("p_rand_rx_err", rx_err_p, 0);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("p_rand_popped", rx_count_p, 0);

        // injected wrong parity bit
        loop = 1'b0;
        tick(2);
        fb = frame_bits(8'd41, PAR_EVEN);
        rx_frame(8'd41, 1'b1, ~fb[1+DW], 1'b1, 2);
        check("pinj_rx_err", rx_err_p, 3'b001);
        check("pinj_rx_count", rx_count_p, 1);
        check("pinj_rx_data", rx_data_p, 8'd41);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("pinj_err_clr", rx_err_p, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_xcvr_param.md
UART_XCVR_PARAM -- requirements
Module: uart_xcvr_param

Interface
REQ-001 SHALL have parameter CLK_DIV, default 347, meaning clock cycles per bit (legal 4..65535).
REQ-002 SHALL have parameter DATA_W, default 8, meaning data bits per frame (legal 5..9).
REQ-003 SHALL have parameter PARITY, default 0, meaning 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal 1..2).
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, meaning RX FIFO entries (power of two, 2..256).
REQ-006 SHALL have port wb_clk_i  input  1  the single clock.
REQ-007 SHALL have port wb_rst_i  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port tx_start  input  1  request to send tx_data.
REQ-009 SHALL have port tx_data  input  DATA_W  word to transmit.
REQ-010 SHALL have port tx_busy  output  1  transmitter not idle.
REQ-011 SHALL have port tx_finish  output  1  one-cycle pulse at the end of the last stop bit.
REQ-012 SHALL have port ser_tx  output  1  serial output, idle high.
REQ-013 SHALL have port ser_rx  input  1  asynchronous serial input.
REQ-014 SHALL have port rx_data  output  DATA_W  FIFO head word.
REQ-015 SHALL have port rx_valid  output  1  FIFO not empty.
REQ-016 SHALL have port rx_ready  input  1  pop the FIFO head when rx_valid is high.
REQ-017 SHALL have port rx_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-018 SHALL have port rx_finish  output  1  one-cycle pulse per received frame, good or bad.
REQ-019 SHALL have port rx_err  output  3  sticky errors {overrun, frame, parity}.
REQ-020 SHALL have port err_clr  input  1  clears rx_err.

Function
REQ-021 TX FSM SHALL use the states IDLE, START, DATA, PAR, STOP; each bit is held for exactly CLK_DIV cycles.
REQ-022 Capture: tx_start high in IDLE captures tx_data on that edge; tx_busy rises the next cycle; ser_tx goes low the next cycle.
REQ-023 Bit order: DATA bits are sent LSB first; PAR is skipped when PARITY=0; even parity makes the count of ones over data+parity even.
REQ-024 STOP: lasts STOP_BITS*CLK_DIV cycles with ser_tx high; its final cycle asserts tx_finish and returns to IDLE; tx_busy falls with the IDLE transition.
REQ-025 tx_start while busy SHALL be ignored; tx_start held high SHALL start back-to-back frames with no idle gap.
REQ-026 RX input SHALL pass a 2-flop synchronizer before use; 2-cycle latency is acceptable.
REQ-027 RX FSM SHALL use the states IDLE, START, DATA, PAR, STOP.
REQ-028 IDLE->START on a synchronized falling edge; at CLK_DIV/2 the line is re-sampled; if high (false start), return to IDLE with no rx_finish.
REQ-029 Later bits are sampled every CLK_DIV cycles from the mid-start sample, LSB first.
REQ-030 Only the first stop bit is checked; 0 sets the frame error; a parity mismatch sets the parity error.
REQ-031 At the first stop sample, pulse rx_finish and push the word to the FIFO even on error; the FSM re-arms to IDLE immediately.
REQ-032 FIFO SHALL be first-word-fall-through: rx_data is valid whenever rx_valid is high; a pop occurs when rx_valid && rx_ready.
REQ-033 Push with count==FIFO_DEPTH and no pop: the word is dropped, the overrun bit is set, and contents are unchanged.
REQ-034 Simultaneous push and pop, any count including full: both are accepted and count is unchanged.
REQ-035 Pointers SHALL wrap modulo FIFO_DEPTH; rx_count is exact from 0 to FIFO_DEPTH.
REQ-036 err_clr SHALL clear rx_err the next cycle; an error set in the same cycle wins.

Reset
REQ-037 On wb_rst_i: both FSMs go to IDLE, ser_tx=1, tx_busy=0, tx_finish=0, rx_finish=0, rx_valid=0, rx_count=0, rx_err=0, synchronizer flops=1, and the FIFO is emptied.
REQ-038 Reset mid-frame SHALL abort the frame; no partial word is pushed and no finish pulse is produced.

Structure
REQ-039 Package uart_pkg SHALL hold the tx/rx state enums, the PARITY encodings (PAR_NONE, PAR_EVEN, PAR_ODD) and the rx_err bit indices.
REQ-040 The RX FIFO SHALL be a sub-module uart_rx_fifo parametrised by DATA_W and FIFO_DEPTH; all other logic is inline.

Verification
REQ-041 CLK_DIV=8, 8N1: send 15 -> ser_tx low 8 cycles, then bits 1,1,1,1,0,0,0,0 at 8 cycles each, then high 8; tx_finish pulses once at cycle 80 after capture.
REQ-042 Loopback ser_tx->ser_rx, send 61 then 79 with tx_start held -> two rx_finish pulses; FIFO yields 61 then 79; rx_err=0.
REQ-043 PARITY=1, tx 41 -> parity bit 1; inject a flipped parity bit on ser_rx -> rx_err=3'b001 and the word is still pushed; err_clr -> 0.
REQ-044 FIFO_DEPTH=4, rx_ready=0, receive 5 frames -> rx_count=4, overrun set, FIFO holds the first 4 words; then a push and pop in the same cycle at full -> count stays 4.
REQ-045 A 3-cycle low glitch on ser_rx -> no rx_finish, FSM back in IDLE; a stop bit forced low -> frame error set.
REQ-046 wb_rst_i asserted mid-TX at data bit 3 -> next cycle ser_tx=1, tx_busy=0, no tx_finish; the next tx_start transmits normally.
